ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
AHB-Lite on-chip SRAM target that sits directly downstream of the user block's AHB master port. It consumes the transfers issued by the read and write masters: bursts, single beats and sub-word accesses. It provides a configurable number of wait states and ERROR responses, so the masters' HREADY/HRESP handling is exercised. Word-addressed internal array, little-endian byte lanes.

Parameters:
ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH 32-bit words (byte range 0 .. 4*depth-1)
WAIT_STATES, 1, HREADYOUT-low cycles inserted in every OKAY data phase (0..15)

Ports:
HCLK  in  1  clock
HRESET  in  1  synchronous active-high reset
HSEL  in  1  slave select
HADDR  in  32  byte address
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWRITE  in  1  1 = write
HSIZE  in  3  000 byte, 001 half, 010 word
HBURST  in  3  ignored; each beat is handled independently
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus ready; qualifies address phase
HRDATA  out  32  read data
HREADYOUT  out  1  slave ready
HRESP  out  2  00 OKAY, 01 ERROR

Behaviour:
- Clock is HCLK; reset is HRESET, synchronous and active-high; one clock domain.
- Reset values: HREADYOUT=1, HRESP=00, HRDATA=0, FSM=IDLE, wait counter=0. Array contents are not reset.
- Address phase is accepted on a rising edge when HSEL & HREADY & HTRANS[1]=1.
  - On acceptance, latch HADDR, HWRITE and HSIZE, and the error flag.
  - Otherwise (IDLE, BUSY, HSEL=0 or HREADY=0), no transfer is accepted. The outputs stay OKAY with HREADYOUT=1.
- Error flag is set by any of:
  - HSIZE > 010;
  - misalignment (half with HADDR[0]=1, word with HADDR[1:0]!=00);
  - HADDR >= 4*depth.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE to WAIT: accepted, no error, WAIT_STATES>0; counter loads WAIT_STATES-1.
  - IDLE to DATA: accepted, no error, WAIT_STATES=0.
  - IDLE to ERR1: accepted with error.
  - WAIT: HREADYOUT=0, HRESP=00. The counter decrements; at 0 the FSM goes to DATA.
  - DATA: HREADYOUT=1, HRESP=00; the transfer completes this cycle.
    - Read: HRDATA = full word mem[addr[ADDR_WIDTH+1:2]], all lanes driven regardless of size.
    - Write: HWDATA is committed at the end of this cycle to the enabled byte lanes only.
  - ERR1: HREADYOUT=0, HRESP=01.
  - ERR2: HREADYOUT=1, HRESP=01. No array write occurs; HRDATA=0.
  - From DATA or ERR2: if a new transfer is accepted in the same cycle (pipelined), go to WAIT, DATA or ERR1 per the same rules; otherwise go to IDLE.
- Byte enables:
  - byte: lane HADDR[1:0];
  - half: lanes {1,0} if HADDR[1]=0, else {3,2};
  - word: all lanes.
- HRDATA is 0 in every cycle except DATA-state reads.
- Zero-wait back-to-back: when a read's data phase directly follows a write to the same word, the read returns the newly written bytes. The write commits at the edge ending its data phase, before the read's data phase.
- A new address phase presented while HREADYOUT=0 is not accepted, because HREADY is low. The master must hold it.
- HRESET asserted mid-transfer (WAIT or DATA): no array write at that edge; all outputs return to reset values the next cycle.

Test Plan:
- WAIT_STATES=1: write word 0xDEADBEEF to 0x10, then read 0x10 → one HREADYOUT-low cycle per data phase; read data phase gives HRDATA=0xDEADBEEF, HRESP=00.
- Byte/half lanes: word write 0x00000000 to 0x20; byte write 0xAA at 0x21 (HWDATA=0x0000AA00); half write 0x1234 at 0x22 (HWDATA=0x12340000); read 0x20 → 0x1234AA00.
- WAIT_STATES=0, 4-beat SEQ incrementing write to 0x40–0x4C (data 1,2,3,4), then an immediate read burst → HREADYOUT constantly 1; reads return 1,2,3,4; a read right after the last write to 0x4C returns 4.
- Errors: word read at 0x02, HSIZE=011 at 0x00, and address 0x1000 (ADDR_WIDTH=10) → each gives HRESP=01 for 2 cycles, HREADYOUT 0 then 1; the array is unchanged (re-read 0x00 returns prior value).
- IDLE/BUSY and HSEL=0 with HTRANS=10 → no access; HREADYOUT=1, HRESP=00, HRDATA=0, memory unchanged.
- WAIT_STATES=3: write 0x55 to 0x8, assert HRESET during the second wait cycle → no write (later read of 0x8 returns old value); the cycle after reset HREADYOUT=1, HRESP=00, HRDATA=0.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM target: word-addressed array with little-endian byte lanes,
// a fixed number of wait states per OKAY data phase and two-cycle ERROR responses.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP
);

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_t                state;
  logic [3:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [3:0]            be_q;
  logic [31:0]           mem [DEPTH];

  logic                  accept;
  logic                  addr_err;
  logic                  commit;
  logic [3:0]            be_in;
  logic [ADDR_WIDTH-1:0] idx_in;
  logic [31:0]           fwd_word;
  logic                  unused_ok;

  assign accept    = HSEL & HREADY & HTRANS[1];
  assign idx_in    = HADDR[ADDR_WIDTH+1:2];
  assign commit    = (state == ST_DATA) & wr_q;
  assign unused_ok = ^{HBURST, HTRANS[0]};

  always_comb begin
    addr_err = 1'b0;
    if (HSIZE > 3'b010)
      addr_err = 1'b1;
    if (HSIZE == 3'b001 && HADDR[0])
      addr_err = 1'b1;
    if (HSIZE == 3'b010 && HADDR[1:0] != 2'b00)
      addr_err = 1'b1;
    if (HADDR[31:ADDR_WIDTH+2] != '0)
      addr_err = 1'b1;
  end

  always_comb begin
    case (HSIZE[1:0])
      2'b00:   be_in = 4'b0001 << HADDR[1:0];
      2'b01:   be_in = HADDR[1] ? 4'b1100 : 4'b0011;
      default: be_in = 4'b1111;
    endcase
  end

  // A zero-wait read accepted while a write to the same word is in its data
  // phase must see the bytes that write commits at this very edge.
  always_comb begin
    fwd_word = mem[idx_in];
    if (commit && addr_q == idx_in) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i])
          fwd_word[8*i +: 8] = HWDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i])
          mem[addr_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      be_q      <= 4'b0000;
      HREADYOUT <= 1'b1;
      HRESP     <= 2'b00;
      HRDATA    <= 32'h0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state     <= ST_DATA;
            HREADYOUT <= 1'b1;
            HRESP     <= 2'b00;
            HRDATA    <= wr_q ? 32'h0 : mem[addr_q];
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 2'b01;
          HRDATA    <= 32'h0;
        end
        default: begin
          if (accept) begin
            addr_q <= idx_in;
            wr_q   <= HWRITE;
            be_q   <= be_in;
            if (addr_err) begin
              state     <= ST_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 2'b01;
              HRDATA    <= 32'h0;
            end else if (WAIT_STATES > 0) begin
              state     <= ST_WAIT;
              wait_cnt  <= 4'(WAIT_STATES - 1);
              HREADYOUT <= 1'b0;
              HRESP     <= 2'b00;
              HRDATA    <= 32'h0;
            end else begin
              state     <= ST_DATA;
              HREADYOUT <= 1'b1;
              HRESP     <= 2'b00;
              HRDATA    <= HWRITE ? 32'h0 : fwd_word;
            end
          end else begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 2'b00;
            HRDATA    <= 32'h0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: three instances (1, 0 and 3 wait states)
// share the bus; the driver queues expected responses, a monitor checks them.
module tb_ahb_sram_slave;

  localparam int AW = 10;
  localparam logic [1:0] NS  = 2'b10;
  localparam logic [1:0] SQ  = 2'b11;
  localparam logic [2:0] SZB = 3'b000;
  localparam logic [2:0] SZH = 3'b001;
  localparam logic [2:0] SZW = 3'b010;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          waits;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hro [3];
  logic [1:0]  hrs [3];
  logic [31:0] hrd [3];
  int          act;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_sram_slave #(
      .ADDR_WIDTH (AW),
      .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 3))
    ) u_dut (
      .HCLK     (clk),
      .HRESET   (rst),
      .HSEL     (hsel[g]),
      .HADDR    (haddr),
      .HTRANS   (htrans),
      .HWRITE   (hwrite),
      .HSIZE    (hsize),
      .HBURST   (hburst),
      .HWDATA   (hwdata),
      .HREADY   (hro[g]),
      .HRDATA   (hrd[g]),
      .HREADYOUT(hro[g]),
      .HRESP    (hrs[g])
    );
  end

  function automatic int ws_of(input int a);
    case (a)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  // monitor: every mid-cycle sample either completes a data phase or must look idle
  bit          pend = 1'b0;
  int          waits = 0;
  logic [1:0]  wresp;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rst) begin
      pend  = 1'b0;
      waits = 0;
      sb.delete();
    end else begin
      if (pend) begin
        if (!hro[act]) begin
          waits++;
          wresp = hrs[act];
        end else begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: data phase completed with nothing expected");
          end else begin
            mon_e = sb.pop_front();
            chk({mon_e.name, "_resp"},  64'(hrs[act]), 64'(mon_e.resp));
            chk({mon_e.name, "_rdata"}, 64'(hrd[act]), 64'(mon_e.data));
            chk({mon_e.name, "_waits"}, 64'(waits),    64'(mon_e.waits));
            if (waits > 0)
              chk({mon_e.name, "_wresp"}, 64'(wresp), 64'(mon_e.resp));
          end
          pend  = 1'b0;
          waits = 0;
        end
      end else begin
        chk("idle_outputs", 64'({hro[act], hrs[act], hrd[act]}), 64'({1'b1, 2'b00, 32'h0}));
      end
      if (hro[act] && hsel[act] && htrans[1])
        pend = 1'b1;
    end
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!hro[act] && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!hro[act]) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: ready low for %0d cycles, want high", name, n);
    end
  endtask

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [1:0] trans, input logic [31:0] wdata,
                      input logic [31:0] exp_data, input bit exp_err, input string name);
    exp_t e;
    hsel   = 3'b001 << act;
    haddr  = addr;
    htrans = trans;
    hwrite = wr;
    hsize  = size;
    e.resp  = exp_err ? 2'b01 : 2'b00;
    e.data  = (wr || exp_err) ? 32'h0 : exp_data;
    e.waits = exp_err ? 1 : ws_of(act);
    e.name  = name;
    sb.push_back(e);
    wait_ready(name);
    @(posedge clk);
    #1;
    if (wr)
      hwdata = wdata;
  endtask

  task automatic go_idle(input int cycles);
    htrans = 2'b00;
    wait_ready("idle");
    repeat (cycles + 1) @(posedge clk);
    #1;
  endtask

  task automatic noacc(input logic [2:0] sel, input logic [1:0] trans, input int cycles);
    hsel   = sel;
    htrans = trans;
    hwrite = 1'b1;
    haddr  = 32'h0;
    hsize  = SZW;
    hwdata = 32'h33333333;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; hsel = 3'b000; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0;
    hsize = SZW; hburst = 3'b000; hwdata = 32'h0; act = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // one wait state: word write/read, byte and half lanes, last valid word
    act = 0;
    xfer(1, 32'h10, SZW, NS, 32'hDEADBEEF, 32'h0, 0, "w10");
    xfer(0, 32'h10, SZW, NS, 32'h0, 32'hDEADBEEF, 0, "r10");
    go_idle(1);
    xfer(1, 32'h20, SZW, NS, 32'h00000000, 32'h0, 0, "w20");
    xfer(1, 32'h21, SZB, NS, 32'h0000AA00, 32'h0, 0, "wb21");
    xfer(1, 32'h22, SZH, NS, 32'h12340000, 32'h0, 0, "wh22");
    xfer(0, 32'h20, SZW, NS, 32'h0, 32'h1234AA00, 0, "r20");
    xfer(1, 32'hFFC, SZW, NS, 32'hA5A5A5A5, 32'h0, 0, "wffc");
    xfer(0, 32'hFFC, SZW, NS, 32'h0, 32'hA5A5A5A5, 0, "rffc");
    go_idle(1);

    // error responses leave the array untouched
    xfer(1, 32'h00, SZW, NS, 32'hCAFEF00D, 32'h0, 0, "w00");
    xfer(0, 32'h02, SZW, NS, 32'h0, 32'h0, 1, "err_mis");
    xfer(1, 32'h01, SZH, NS, 32'h44444444, 32'h0, 1, "err_half");
    xfer(1, 32'h00, 3'b011, NS, 32'h11111111, 32'h0, 1, "err_size");
    xfer(1, 32'h1000, SZW, NS, 32'h22222222, 32'h0, 1, "err_range");
    xfer(0, 32'h00, SZW, NS, 32'h0, 32'hCAFEF00D, 0, "r00_after_err");
    go_idle(1);

    // IDLE, BUSY and deselected NONSEQ must not access the array
    noacc(3'b001, 2'b00, 2);
    noacc(3'b001, 2'b01, 2);
    noacc(3'b000, 2'b10, 2);
    xfer(0, 32'h00, SZW, NS, 32'h0, 32'hCAFEF00D, 0, "r00_after_noacc");
    go_idle(1);

    // zero wait states: burst write, forwarded read, burst read, partial forward
    act = 1;
    xfer(1, 32'h40, SZW, NS, 32'h1, 32'h0, 0, "bw40");
    xfer(1, 32'h44, SZW, SQ, 32'h2, 32'h0, 0, "bw44");
    xfer(1, 32'h48, SZW, SQ, 32'h3, 32'h0, 0, "bw48");
    xfer(1, 32'h4C, SZW, SQ, 32'h4, 32'h0, 0, "bw4c");
    xfer(0, 32'h4C, SZW, NS, 32'h0, 32'h4, 0, "r4c_fwd");
    xfer(0, 32'h40, SZW, NS, 32'h0, 32'h1, 0, "br40");
    xfer(0, 32'h44, SZW, SQ, 32'h0, 32'h2, 0, "br44");
    xfer(0, 32'h48, SZW, SQ, 32'h0, 32'h3, 0, "br48");
    xfer(0, 32'h4C, SZW, SQ, 32'h0, 32'h4, 0, "br4c");
    xfer(1, 32'h50, SZW, NS, 32'h11223344, 32'h0, 0, "w50");
    xfer(1, 32'h51, SZB, NS, 32'h0000EE00, 32'h0, 0, "wb51");
    xfer(0, 32'h50, SZW, NS, 32'h0, 32'h1122EE44, 0, "r50_fwd");
    go_idle(1);

    // three wait states: reset during the second wait cycle cancels the write
    act = 2;
    xfer(1, 32'h08, SZW, NS, 32'h0BADF00D, 32'h0, 0, "w08");
    go_idle(1);
    xfer(1, 32'h08, SZW, NS, 32'h00000055, 32'h0, 0, "w08_rst");
    htrans = 2'b00;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    xfer(0, 32'h08, SZW, NS, 32'h0, 32'h0BADF00D, 0, "r08_after_rst");
    go_idle(2);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected responses left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
